// File: rtl/udp_txrx_ctrl.sv
// rtl/udp_txrx_ctrl.sv - UDP RX/TX buffer controller with echo copy, periodic and one-shot TX
module udp_txrx_ctrl #(
    parameter int AWIDTH   = 6,
    parameter int PERIOD_W = 28
) (
    input  logic                clk_int,
    input  logic                rst_n,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic                tx_trig,
    input  logic                cpu_wr_en,
    input  logic [AWIDTH-1:0]   cpu_wr_addr,
    input  logic [31:0]         cpu_wr_data,
    input  logic                rxbuf_we,
    input  logic [AWIDTH-1:0]   rxbuf_addr,
    input  logic [31:0]         rxbuf_wdata,
    input  logic                rxbuf_cpu_grant,
    output logic                rxbuf_cpu_rel,
    input  logic                txbuf_cpu_grant,
    output logic                txbuf_cpu_rel,
    input  logic [AWIDTH-1:0]   txbuf_addr,
    output logic [31:0]         txbuf_rdata,
    output logic [15:0]         rx_len,
    output logic [15:0]         rx_pkt_cnt,
    output logic [15:0]         tx_pkt_cnt,
    output logic                tx_ovr,
    output logic                busy
);
    localparam int DEPTH = 2 ** AWIDTH;
    // Word-count arithmetic must hold 3 + (0xFFFF+3)/4 as well as DEPTH itself.
    localparam int LW = (AWIDTH + 1 > 17) ? AWIDTH + 1 : 17;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COPY   = 2'd1,
        RX_REL = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]         rx_mem [DEPTH];
    logic [31:0]         tx_mem [DEPTH];
    logic                armed;
    logic [AWIDTH-1:0]   copy_idx;
    logic [LW-1:0]       len_words;
    logic [LW-1:0]       copy_len;
    logic                copy_last;
    logic                copy_done;
    logic [31:0]         copy_word;
    logic                accept;
    logic [PERIOD_W-1:0] timer;
    logic                timer_run;
    logic                timer_hit;
    logic                tx_req;
    logic                tx_fire;
    logic                tx_pend;

    assign accept    = (state == IDLE) && rxbuf_cpu_grant && armed;
    assign len_words = ((LW'(rx_len) + LW'(3)) >> 2) + LW'(3);
    assign copy_len  = (len_words > LW'(DEPTH)) ? LW'(DEPTH) : len_words;
    assign copy_last = (LW'(copy_idx) == copy_len - LW'(1));

    assign timer_run = (mode == 2'b01) && (period != '0);
    assign timer_hit = timer_run && (timer == period - PERIOD_W'(1));

    assign tx_req  = copy_done || timer_hit || ((mode == 2'b10) && tx_trig);
    assign tx_fire = tx_pend && txbuf_cpu_grant && (state != COPY);

    assign rxbuf_cpu_rel = (state == RX_REL);
    assign busy          = (state != IDLE) || tx_pend;
    assign txbuf_rdata   = tx_mem[txbuf_addr];

    // Stack writes land in the RX buffer unconditionally.
    always_ff @(posedge clk_int) begin
        if (rxbuf_we) begin
            rx_mem[rxbuf_addr] <= rxbuf_wdata;
        end
    end

    // TX buffer: the echo copy owns the write port while copying; CPU writes are dropped then.
    always_ff @(posedge clk_int) begin
        if (state == COPY) begin
            tx_mem[copy_idx] <= copy_word;
        end else if (cpu_wr_en) begin
            tx_mem[cpu_wr_addr] <= cpu_wr_data;
        end
    end

    // Echo header rewrite: swap ports into the TX header and insert the payload length.
    always_comb begin
        copy_word = rx_mem[copy_idx];
        if (copy_idx == AWIDTH'(1)) begin
            copy_word = {rx_mem[2][15:0], rx_mem[1][15:0]};
        end else if (copy_idx == AWIDTH'(2)) begin
            copy_word = {16'h0000, rx_len};
        end
    end

    // FSM state register.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; copy completion is flagged on the last copy cycle.
    always_comb begin
        state_nxt = state;
        copy_done = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (mode == 2'b11) ? COPY : RX_REL;
                end
            end
            COPY: begin
                if (copy_last) begin
                    copy_done = 1'b1;
                    state_nxt = RX_REL;
                end
            end
            RX_REL:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RX episode bookkeeping: arming, length latch, packet count and copy index.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b1;
            rx_len     <= 16'h0000;
            rx_pkt_cnt <= 16'h0000;
            copy_idx   <= '0;
        end else begin
            if (!rxbuf_cpu_grant) begin
                armed <= 1'b1;
            end else if (accept) begin
                armed <= 1'b0;
            end
            if (accept) begin
                rx_len     <= rx_mem[1][31:16];
                rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
                copy_idx   <= '0;
            end else if ((state == COPY) && !copy_last) begin
                copy_idx <= copy_idx + AWIDTH'(1);
            end
        end
    end

    // Periodic timer, held at zero unless periodic mode with a non-zero period.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (timer_run && !timer_hit) begin
            timer <= timer + PERIOD_W'(1);
        end else begin
            timer <= '0;
        end
    end

    // TX pending/release: requests coalesce; overrun flagged only when no release absorbs it.
    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            tx_pend       <= 1'b0;
            txbuf_cpu_rel <= 1'b0;
            tx_ovr        <= 1'b0;
            tx_pkt_cnt    <= 16'h0000;
        end else begin
            tx_pend       <= tx_req || (tx_pend && !tx_fire);
            txbuf_cpu_rel <= tx_fire;
            tx_ovr        <= tx_req && tx_pend && !tx_fire;
            if (tx_fire) begin
                tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
            end
        end
    end

endmodule
